// File: rtl/ex3_to_bin_seq.sv
// Sequential Excess-3 to binary decoder: one digit per clock via acc*10 + d.
// Optional saturating illegal-word counter output enabled by EX3_ERR_CNT_EN.
module ex3_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BIN_W-1:0]    out_bin,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
`ifdef EX3_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam int IW = 4 * DIGITS;
  localparam int AW = BIN_W + 4;

  // Handshake semantics: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, both from registered state.
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     shreg, shreg_nxt;
  logic [BIN_W-1:0]  acc, acc_nxt;
  logic [BIN_W-1:0]  out_bin_nxt;
  logic              err, err_nxt;
  logic              out_err_nxt;
  logic [3:0]        count, count_nxt;
  logic [3:0]        c;
  logic [3:0]        d;
  logic              legal;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign c     = shreg[IW-1 -: 4];
  assign legal = (c >= 4'd3) && (c <= 4'd12);
  assign d     = legal ? (c - 4'd3) : 4'd0;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    acc_nxt     = acc;
    err_nxt     = err;
    count_nxt   = count;
    out_bin_nxt = out_bin;
    out_err_nxt = out_err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_nxt = in_data;
          acc_nxt   = '0;
          err_nxt   = 1'b0;
          count_nxt = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        // Multiply-accumulate at BIN_W+4 bits, truncated back to the output width.
        acc_nxt   = BIN_W'(({4'b0000, acc} * AW'(10)) + AW'(d));
        err_nxt   = err | ~legal;
        shreg_nxt = shreg << 4;
        count_nxt = count + 4'd1;
        if (count == 4'(DIGITS - 1)) begin
          out_bin_nxt = acc_nxt;
          out_err_nxt = err_nxt;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= '0;
      err     <= 1'b0;
      count   <= '0;
      out_bin <= '0;
      out_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      acc     <= acc_nxt;
      err     <= err_nxt;
      count   <= count_nxt;
      out_bin <= out_bin_nxt;
      out_err <= out_err_nxt;
    end
  end

`ifdef EX3_ERR_CNT_EN
  // Counts delivered words that carried an illegal digit; sticks at 255.
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/ex3_to_bin_seq.md
Name: ex3_to_bin_seq

Overview:
- Sequential Excess-3 to binary decoder. It is the receive-side counterpart of the binary-to-Excess-3 add-3 converter.
- Accepts one packed word of DIGITS Excess-3 digits and converts it to an unsigned binary value, one digit per clock, using multiply-by-10-and-add.
- Flags any digit code outside the legal Excess-3 range.
- Valid/ready handshake on both sides, so it can sit between the Excess-3 link and downstream binary arithmetic.

Parameters:
- DIGITS, default 2: number of Excess-3 digits per input word. Input width is 4*DIGITS. Must be 1 to 8.
- BIN_W, default 7: binary output width. Must satisfy 10^DIGITS - 1 <= 2^BIN_W - 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  4*DIGITS  Excess-3 word; most significant digit in the top nibble.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- out_bin  output  BIN_W  converted binary value.
- out_err  output  1  at least one digit of the word was an illegal code.
- out_valid  output  1  out_bin/out_err are valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, internal accumulator=0, digit counter=0, shift register=0.
- Reset mid-operation: a conversion in CONV or DONE is abandoned with no output.
- FSM states: IDLE, CONV, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state.
- IDLE:
  - On in_valid && in_ready: load in_data into the shift register, clear acc, err and count, and go to CONV.
  - in_valid without a handshake has no effect.
- CONV, each cycle:
  - Take the top nibble c of the shift register.
  - Legal iff 3 <= c <= 12. Legal: d = c - 3. Illegal: d = 0 and set err.
  - acc <= acc*10 + d, computed at BIN_W+4 bits and truncated to BIN_W. No truncation occurs for legal input when BIN_W meets its constraint.
  - Shift the register left by 4 and increment count.
  - When count reaches DIGITS-1 on this cycle: register out_bin <= the final acc value, out_err <= final err, and go to DONE.
- Latency: out_valid rises exactly DIGITS cycles after the accepting edge.
- DONE:
  - out_bin and out_err are held stable while out_ready=0 (unlimited backpressure).
  - On out_ready=1, go to IDLE. out_valid drops next cycle.
  - No new word is accepted in the same cycle; in_ready rises one cycle after the output handshake.
  - Throughput: one word per DIGITS+2 cycles under continuous traffic.
- in_data changes while in CONV/DONE are ignored; the captured copy is used.
- out_bin/out_err keep their last values in IDLE and CONV. Their values are meaningful only while out_valid=1.
- DIGITS=1: CONV lasts one cycle.

Optional Feature:
- Macro: EX3_ERR_CNT_EN.
- When defined:
  - Extra output port err_cnt, 8 bits, reset to 0.
  - Increments by 1 on each output handshake (out_valid && out_ready) with out_err=1.
  - Saturates at 255; no wrap.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- DIGITS=2. Send 8'h33, 8'hCC, 8'h45, 8'h58 back-to-back with out_ready=1 -> out_bin 0, 99, 12, 25 with out_err=0. out_valid rises 2 cycles after each accept. in_ready is low for 3 cycles per word.
- Illegal codes: 8'hFF -> out_bin 0, out_err 1. 8'h3F -> out_bin 0, out_err 1. 8'h2A -> out_bin 7, out_err 1.
- Backpressure: 8'h4A with out_ready held 0 for 5 cycles -> out_valid=1 and out_bin=17 stable throughout, in_ready=0. Raising out_ready completes the transfer and in_ready returns to 1 one cycle later.
- Reset mid-conversion: accept 8'h99, assert rst on the next cycle -> all outputs at reset values and no out_valid pulse. A following 8'h36 converts to 3.
- DIGITS=3, BIN_W=10: 12'hCCC -> 999 with latency 3. 12'h433 -> 100.
- With EX3_ERR_CNT_EN: 3 illegal words, then 1 legal word -> err_cnt=3. 300 illegal words -> err_cnt=255.
